game_count_mc: RTL and testbench
================================

Name: game_count_mc

Overview:
- Multi-channel, parametrised successor of the single-station game counter.
- Each of CH stations holds a credit balance that is loaded or topped up by money, then drained at a programmable tick rate. Boost drains faster.
- Per-station red/yellow status and a one-cycle expiry pulse are provided.
- Sits between the coin/payment front end and the station lamp/lock logic. A shared read port exposes any station's remaining credit.

Parameters:
- CH, 4, number of stations (1..16).
- W, 10, credit width in bits; max balance is 2^W-1.
- TICK_DIV, 4, clk cycles per drain tick (>=1; 1 means every cycle).
- BOOST_RATE, 2, units drained per tick while boost is high (>=1).
- WARN_THRESH, 10, yellow asserts when 0 < balance <= WARN_THRESH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- set  in  1  load/top-up strobe, sampled each cycle.
- set_ch  in  $clog2(CH) (min 1)  target station for set.
- money  in  W  credit units to add on set.
- boost  in  CH  per-station boost enable, level.
- pause  in  CH  per-station pause, level; freezes drain.
- rd_ch  in  $clog2(CH) (min 1)  station selected for remain.
- red  out  CH  1 = station has zero balance (locked).
- yellow  out  CH  1 = station balance low.
- expire  out  CH  one-cycle pulse when a station drains to 0.
- remain  out  W  balance of station rd_ch, combinational mux of registered balances.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all balances = 0, red = all 1, yellow = 0, expire = 0, prescaler = 0.
  - Reset mid-operation discards all credit and state the same way; no output glitches beyond the normal register update.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 in the cycle the count equals TICK_DIV-1. The prescaler is shared by all stations and free-runs regardless of station state.
- Per-station state, derived from the balance and pause input:
  - IDLE: bal = 0.
  - RUN: bal > 0 and pause = 0.
  - PAUSED: bal > 0 and pause = 1.
- Load/top-up:
  - On set=1 with money != 0: bal[set_ch] <= min(bal + money, 2^W-1), computed W+1 bits wide, then saturated.
  - IDLE goes to RUN, or to PAUSED if pause is high.
  - set with money = 0 is a no-op.
  - set_ch >= CH is ignored.
- Drain: on tick, each RUN station decrements by d, where d = BOOST_RATE if boost=1, else 1. The result floors at 0 (bal < d gives 0). IDLE and PAUSED stations do not change.
- Simultaneous set and tick on the same station: the set wins. That station adds money and skips the decrement that cycle. Other stations drain normally.
- Expire: expire[i] = 1 for exactly the cycle after the drain that moves bal[i] from >0 to 0; otherwise 0. It is registered, aligned with red rising.
- Outputs, registered and updated from the next-state balance:
  - red[i] = (bal[i] == 0).
  - yellow[i] = (bal[i] != 0) && (bal[i] <= WARN_THRESH).
  - red and yellow are never both 1.
- remain reflects the balance after the most recent edge, with no extra latency. rd_ch >= CH gives remain = 0.
- Latency:
  - set to updated balance/red/yellow: 1 cycle.
  - tick to decremented balance: 1 cycle.
- Pause and boost are level inputs sampled on the tick cycle only. Changes between ticks have no effect until the next tick.

Test Plan:
- Reset, then set=1, set_ch=2, money=5, TICK_DIV=4, no boost: red[2] falls and yellow[2]=1 the next cycle. Balance reads 4,3,2,1,0 at successive ticks. expire[2] pulses once, red[2]=1 after 20 cycles +/- prescaler phase. Other stations stay red.
- boost[1]=1, money=7, BOOST_RATE=2: ticks give 5,3,1,0. The final tick floors at 0, not underflow. expire[1] pulses once.
- Top-up saturation, W=10: set money=1000, then money=100 on the same station gives balance 1023. remain shows 1023 on rd_ch.
- Set on a tick cycle for a running station with bal=12, money=3: balance is 15, with no decrement that cycle. The next tick gives 14. yellow goes 0 at 15, and returns to 1 once bal <= 10.
- pause[0]=1 with bal=8 for 3 ticks: balance holds at 8. On release it resumes 7,6,... Set while paused adds credit and stays PAUSED.
- Assert rst_n=0 for one cycle mid-drain with several stations nonzero: all balances 0, red all 1, yellow/expire 0, no expire pulse generated by the reset.

Source files
------------

// File: rtl/game_count_mc.sv
// game_count_mc: multi-station credit counter.
// Each station holds a credit balance. Money loads or tops up the balance,
// and a shared prescaler drains it at a fixed tick rate. Boost drains faster.
// Per-station red/yellow status and a one-cycle expiry pulse are registered.
// A shared read port muxes out any station's balance.
module game_count_mc #(
    parameter int CH          = 4,
    parameter int W           = 10,
    parameter int TICK_DIV    = 4,
    parameter int BOOST_RATE  = 2,
    parameter int WARN_THRESH = 10,
    localparam int CW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set,
    input  logic [CW-1:0] set_ch,
    input  logic [W-1:0]  money,
    input  logic [CH-1:0] boost,
    input  logic [CH-1:0] pause,
    input  logic [CW-1:0] rd_ch,
    output logic [CH-1:0] red,
    output logic [CH-1:0] yellow,
    output logic [CH-1:0] expire,
    output logic [W-1:0]  remain
);

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXV = (1 << W) - 1;

    // Drain step and warning limit are clamped to the balance range so that
    // they can be compared directly against a W-bit balance.
    localparam logic [W-1:0] BOOST_DEC = (BOOST_RATE > MAXV) ? W'(MAXV) : W'(BOOST_RATE);
    localparam logic [W-1:0] WARN_LIM  = (WARN_THRESH > MAXV) ? W'(MAXV) : W'(WARN_THRESH);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Station state is not stored separately; it follows from balance and pause.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED
    } station_state_e;

    logic [PW-1:0]  cnt_q, cnt_d;
    logic           tick;
    logic [W-1:0]   bal_q [CH];
    logic [W-1:0]   bal_d [CH];
    logic [CH-1:0]  red_q, red_d;
    logic [CH-1:0]  yellow_q, yellow_d;
    logic [CH-1:0]  expire_q, expire_d;
    station_state_e st [CH];

    // Free-running shared prescaler; tick marks the last count of each period.
    always_comb begin
        tick  = (cnt_q == TICK_LAST);
        cnt_d = tick ? '0 : cnt_q + PW'(1);
    end

    // Decode each station's state from its balance and pause level.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            if (bal_q[i] == '0) begin
                st[i] = ST_IDLE;
            end else if (pause[i]) begin
                st[i] = ST_PAUSED;
            end else begin
                st[i] = ST_RUN;
            end
        end
    end

    // Next balance per station: a top-up beats a drain on the same cycle.
    always_comb begin
        logic [W:0]   sum;
        logic [W-1:0] dec;
        sum      = '0;
        dec      = '0;
        expire_d = '0;
        red_d    = '0;
        yellow_d = '0;
        for (int i = 0; i < CH; i++) begin
            bal_d[i] = bal_q[i];
            if (set && (money != '0) && (set_ch == CW'(i))) begin
                sum      = {1'b0, bal_q[i]} + {1'b0, money};
                bal_d[i] = sum[W] ? W'(MAXV) : sum[W-1:0];
            end else if (tick && (st[i] == ST_RUN)) begin
                dec = boost[i] ? BOOST_DEC : W'(1);
                if (bal_q[i] <= dec) begin
                    bal_d[i]    = '0;
                    expire_d[i] = 1'b1;
                end else begin
                    bal_d[i] = bal_q[i] - dec;
                end
            end
            red_d[i]    = (bal_d[i] == '0);
            yellow_d[i] = (bal_d[i] != '0) && (bal_d[i] <= WARN_LIM);
        end
    end

    // State registers; reset clears all credit and locks every station.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            bal_q    <= '{default: '0};
            red_q    <= '1;
            yellow_q <= '0;
            expire_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            bal_q    <= bal_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            expire_q <= expire_d;
        end
    end

    // Read port: select a registered balance, zero for an unused channel code.
    always_comb begin
        remain = '0;
        for (int i = 0; i < CH; i++) begin
            if (rd_ch == CW'(i)) begin
                remain = bal_q[i];
            end
        end
    end

    assign red    = red_q;
    assign yellow = yellow_q;
    assign expire = expire_q;

endmodule

// File: tb/tb_game_count_mc.sv
// Testbench for game_count_mc: directed vectors, expected values queued by
// the stimulus and checked by an independent negedge monitor.
module tb_game_count_mc;

    localparam int CH = 4;
    localparam int W  = 10;

    localparam int K_REM = 0;
    localparam int K_RED = 1;
    localparam int K_YEL = 2;
    localparam int K_EXP = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          set;
    logic [1:0]    set_ch;
    logic [W-1:0]  money;
    logic [CH-1:0] boost;
    logic [CH-1:0] pause;
    logic [1:0]    rd_ch;
    logic [CH-1:0] red;
    logic [CH-1:0] yellow;
    logic [CH-1:0] expire;
    logic [W-1:0]  remain;

    typedef struct {
        int    due;
        int    kind;
        int    val;
        string name;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    game_count_mc #(
        .CH(CH), .W(W), .TICK_DIV(4), .BOOST_RATE(2), .WARN_THRESH(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .set(set), .set_ch(set_ch), .money(money),
        .boost(boost), .pause(pause), .rd_ch(rd_ch),
        .red(red), .yellow(yellow), .expire(expire), .remain(remain)
    );

    // 10 ns clock; cyc counts rising edges seen so far.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Park just after rising edge n so that new inputs are sampled at edge n+1.
    task automatic waitEdge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle set strobe issued after edge 'at', sampled at edge at+1.
    task automatic applyStimulus(input int at, input int ch, input int m);
        waitEdge(at);
        set    = 1'b1;
        set_ch = 2'(ch);
        money  = W'(m);
        waitEdge(at + 1);
        set    = 1'b0;
        money  = '0;
    endtask

    task automatic expectAt(input int due, input int kind, input int val, input string name);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        case (e.kind)
            K_REM:   act = 32'(remain);
            K_RED:   act = 32'(red);
            K_YEL:   act = 32'(yellow);
            default: act = 32'(expire);
        endcase
        total++;
        if (act !== 32'(e.val)) begin
            bad++;
            $display("[TB] FAIL %s at cyc %0d: got 0x%0h, want 0x%0h", e.name, cyc, act, e.val);
        end
    endtask

    // Monitor: outputs are presented every cycle; check whatever is due now.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("[TB] FAIL %s missed: due cyc %0d, now %0d", e.name, e.due, cyc);
            end else begin
                checkOutput(e);
            end
        end
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #5000;
        total++;
        bad++;
        $display("[TB] FAIL watchdog: got timeout, want finish by cyc 106");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Directed stimulus. Reset ends at edge 2, so drain edges are 6, 10, 14, ...
    initial begin
        rst_n  = 1'b0;
        set    = 1'b0;
        set_ch = '0;
        money  = '0;
        boost  = '0;
        pause  = '0;
        rd_ch  = 2'd2;

        // Reset state, then basic drain of station 2 from 5.
        $display("[TB] reset and basic drain");
        expectAt(2,  K_RED, 4'b1111, "rst_red");
        expectAt(2,  K_YEL, 4'b0000, "rst_yellow");
        expectAt(2,  K_EXP, 4'b0000, "rst_expire");
        expectAt(2,  K_REM, 0,       "rst_remain");
        expectAt(3,  K_REM, 5,       "ch2_load");
        expectAt(3,  K_RED, 4'b1011, "ch2_red_fall");
        expectAt(3,  K_YEL, 4'b0100, "ch2_yellow");
        expectAt(5,  K_REM, 5,       "ch2_pre_tick");
        expectAt(6,  K_REM, 4,       "ch2_tick1");
        expectAt(10, K_REM, 3,       "ch2_tick2");
        expectAt(14, K_REM, 2,       "ch2_tick3");
        expectAt(18, K_REM, 1,       "ch2_tick4");
        expectAt(21, K_REM, 1,       "ch2_before_empty");
        expectAt(21, K_EXP, 4'b0000, "ch2_no_early_expire");
        expectAt(22, K_REM, 0,       "ch2_empty");
        expectAt(22, K_EXP, 4'b0100, "ch2_expire");
        expectAt(22, K_RED, 4'b1111, "ch2_red_rise");
        expectAt(22, K_YEL, 4'b0000, "ch2_yellow_off");
        expectAt(23, K_EXP, 4'b0000, "ch2_expire_once");
        waitEdge(2);
        rst_n = 1'b1;
        applyStimulus(2, 2, 5);

        // Boosted drain of station 1 from 7, flooring at zero.
        waitEdge(23);
        $display("[TB] boost drain");
        rd_ch = 2'd1;
        boost = 4'b0010;
        expectAt(24, K_REM, 7,       "ch1_load");
        expectAt(24, K_RED, 4'b1101, "ch1_red");
        expectAt(24, K_YEL, 4'b0010, "ch1_yellow");
        expectAt(26, K_REM, 5,       "ch1_boost1");
        expectAt(30, K_REM, 3,       "ch1_boost2");
        expectAt(34, K_REM, 1,       "ch1_boost3");
        expectAt(37, K_EXP, 4'b0000, "ch1_no_early_expire");
        expectAt(38, K_REM, 0,       "ch1_floor");
        expectAt(38, K_EXP, 4'b0010, "ch1_expire");
        expectAt(38, K_RED, 4'b1111, "ch1_red_rise");
        expectAt(39, K_EXP, 4'b0000, "ch1_expire_once");
        applyStimulus(23, 1, 7);

        // Top-up saturation on station 3, then a zero-money set.
        waitEdge(39);
        $display("[TB] saturation");
        boost = '0;
        rd_ch = 2'd3;
        expectAt(40, K_REM, 1000,    "ch3_load");
        expectAt(40, K_YEL, 4'b0000, "ch3_no_yellow");
        expectAt(41, K_REM, 1023,    "ch3_saturate");
        expectAt(41, K_RED, 4'b0111, "ch3_red");
        expectAt(42, K_REM, 1022,    "ch3_tick");
        expectAt(43, K_REM, 1022,    "ch3_zero_money_noop");
        expectAt(43, K_RED, 4'b0111, "ch3_red_hold");
        applyStimulus(39, 3, 1000);
        applyStimulus(40, 3, 100);
        applyStimulus(42, 3, 0);

        // Set on a tick cycle: station 0 at 12 gets +3 and skips the drain.
        $display("[TB] set on tick");
        expectAt(44, K_REM, 13,      "ch0_load");
        expectAt(44, K_RED, 4'b0110, "ch0_red");
        expectAt(44, K_YEL, 4'b0000, "ch0_no_yellow");
        expectAt(46, K_REM, 12,      "ch0_tick");
        expectAt(49, K_REM, 12,      "ch0_before_set_tick");
        expectAt(50, K_REM, 15,      "ch0_set_wins");
        expectAt(50, K_YEL, 4'b0000, "ch0_yellow_15");
        expectAt(54, K_REM, 14,      "ch0_resume");
        expectAt(69, K_REM, 11,      "ch0_at_11");
        expectAt(69, K_YEL, 4'b0000, "ch0_yellow_11");
        expectAt(70, K_REM, 10,      "ch0_at_10");
        expectAt(70, K_YEL, 4'b0001, "ch0_yellow_10");
        applyStimulus(43, 0, 13);
        rd_ch = 2'd0;
        applyStimulus(49, 0, 3);

        // Pause station 0 at 8; top up while paused; release and resume.
        waitEdge(78);
        $display("[TB] pause");
        pause = 4'b0001;
        expectAt(78, K_REM, 8,       "ch0_at_8");
        expectAt(78, K_YEL, 4'b0001, "ch0_yellow_8");
        expectAt(82, K_REM, 8,       "ch0_pause_hold1");
        expectAt(84, K_REM, 8,       "ch0_pause_hold2");
        expectAt(85, K_REM, 10,      "ch0_paused_topup");
        expectAt(85, K_YEL, 4'b0001, "ch0_paused_yellow");
        expectAt(85, K_RED, 4'b0110, "ch0_paused_red");
        expectAt(90, K_REM, 10,      "ch0_pause_hold3");
        expectAt(94, K_REM, 9,       "ch0_resume1");
        expectAt(98, K_REM, 8,       "ch0_resume2");
        applyStimulus(84, 0, 2);
        waitEdge(91);
        pause = '0;

        // Reset mid-drain, then confirm the prescaler restarted from zero.
        waitEdge(99);
        $display("[TB] mid-run reset");
        rd_ch = 2'd3;
        rst_n = 1'b0;
        expectAt(100, K_REM, 0,       "mrst_ch3_remain");
        expectAt(100, K_RED, 4'b1111, "mrst_red");
        expectAt(100, K_YEL, 4'b0000, "mrst_yellow");
        expectAt(100, K_EXP, 4'b0000, "mrst_expire");
        expectAt(101, K_REM, 1,       "post_ch1_load");
        expectAt(101, K_RED, 4'b1101, "post_ch1_red");
        expectAt(101, K_YEL, 4'b0010, "post_ch1_yellow");
        expectAt(101, K_EXP, 4'b0000, "post_no_expire");
        expectAt(103, K_REM, 1,       "post_ch1_pre_tick");
        expectAt(104, K_REM, 0,       "post_ch1_tick");
        expectAt(104, K_EXP, 4'b0010, "post_ch1_expire");
        expectAt(104, K_RED, 4'b1111, "post_ch1_red_rise");
        expectAt(105, K_EXP, 4'b0000, "post_ch1_expire_once");
        waitEdge(100);
        rst_n = 1'b1;
        applyStimulus(100, 1, 1);
        rd_ch = 2'd1;

        waitEdge(106);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL %s never checked: due cyc %0d, now %0d", e.name, e.due, cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
